// File: rtl/id_decode_stage.sv
// Instruction-decode stage: logic/shift subset decode, operand forwarding,
// load-use stall detection and a valid/ready ID/EX pipeline register.
module id_decode_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned FWD_N  = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              pc_i,
  input  logic [31:0]              inst_i,
  input  logic                     flush,
  output logic [REG_AW-1:0]        rf_raddr1,
  output logic [REG_AW-1:0]        rf_raddr2,
  input  logic [DATA_W-1:0]        rf_rdata1,
  input  logic [DATA_W-1:0]        rf_rdata2,
  input  logic [FWD_N-1:0]         fwd_wreg,
  input  logic [FWD_N*REG_AW-1:0]  fwd_wd,
  input  logic [FWD_N*DATA_W-1:0]  fwd_wdata,
  input  logic [FWD_N-1:0]         fwd_pend,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               aluop_o,
  output logic [2:0]               alusel_o,
  output logic [DATA_W-1:0]        reg1_o,
  output logic [DATA_W-1:0]        reg2_o,
  output logic [REG_AW-1:0]        wd_o,
  output logic                     wreg_o,
  output logic [31:0]              pc_o,
  output logic                     illegal_o,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_AND = 8'h24;
  localparam logic [7:0] OP_OR  = 8'h25;
  localparam logic [7:0] OP_XOR = 8'h26;
  localparam logic [7:0] OP_NOR = 8'h27;
  localparam logic [7:0] OP_SLL = 8'h7C;
  localparam logic [7:0] OP_SRL = 8'h02;
  localparam logic [7:0] OP_SRA = 8'h03;
  localparam logic [2:0] SEL_LOGIC = 3'd1;
  localparam logic [2:0] SEL_SHIFT = 3'd2;

  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd, sa;
  assign op    = inst_i[31:26];
  assign rs    = inst_i[25:21];
  assign rt    = inst_i[20:16];
  assign rd    = inst_i[15:11];
  assign sa    = inst_i[10:6];
  assign funct = inst_i[5:0];

  logic [7:0]        dec_aluop;
  logic [2:0]        dec_alusel;
  logic              re1, re2, sa_sel, imm_sel, dec_wreg, dec_ill;
  logic [REG_AW-1:0] dec_wd;
  logic [DATA_W-1:0] dec_imm;

  // Instruction decode
  always_comb begin
    dec_aluop  = OP_NOP;
    dec_alusel = 3'd0;
    re1        = 1'b0;
    re2        = 1'b0;
    sa_sel     = 1'b0;
    imm_sel    = 1'b0;
    dec_wreg   = 1'b0;
    dec_ill    = 1'b0;
    dec_wd     = '0;
    dec_imm    = '0;
    case (op)
      6'h00: begin
        if (funct == 6'h0F) begin
          dec_aluop = OP_NOP;
        end else if (sa == 5'd0 && (funct == 6'h24 || funct == 6'h25 ||
                                    funct == 6'h26 || funct == 6'h27)) begin
          dec_aluop  = {2'b00, funct};
          dec_alusel = SEL_LOGIC;
          re1 = 1'b1; re2 = 1'b1; dec_wd = REG_AW'(rd); dec_wreg = 1'b1;
        end else if (sa == 5'd0 && (funct == 6'h04 || funct == 6'h06 ||
                                    funct == 6'h07)) begin
          dec_aluop  = (funct == 6'h04) ? OP_SLL : (funct == 6'h06) ? OP_SRL : OP_SRA;
          dec_alusel = SEL_SHIFT;
          re1 = 1'b1; re2 = 1'b1; dec_wd = REG_AW'(rd); dec_wreg = 1'b1;
        end else if (rs == 5'd0 && (funct == 6'h00 || funct == 6'h02 ||
                                    funct == 6'h03)) begin
          dec_aluop  = (funct == 6'h00) ? OP_SLL : (funct == 6'h02) ? OP_SRL : OP_SRA;
          dec_alusel = SEL_SHIFT;
          sa_sel = 1'b1; re2 = 1'b1; dec_wd = REG_AW'(rd); dec_wreg = 1'b1;
        end else begin
          dec_ill = 1'b1;
        end
      end
      6'h0C, 6'h0D, 6'h0E: begin
        dec_aluop  = (op == 6'h0C) ? OP_AND : (op == 6'h0D) ? OP_OR : OP_XOR;
        dec_alusel = SEL_LOGIC;
        re1 = 1'b1; imm_sel = 1'b1; dec_imm = DATA_W'(inst_i[15:0]);
        dec_wd = REG_AW'(rt); dec_wreg = 1'b1;
      end
      6'h0F: begin
        dec_aluop  = OP_OR;
        dec_alusel = SEL_LOGIC;
        re1 = 1'b1; imm_sel = 1'b1; dec_imm = DATA_W'({inst_i[15:0], 16'h0000});
        dec_wd = REG_AW'(rt); dec_wreg = 1'b1;
      end
      6'h33: dec_aluop = OP_NOP;
      default: dec_ill = 1'b1;
    endcase
  end

  assign rf_raddr1 = re1 ? REG_AW'(rs) : '0;
  assign rf_raddr2 = re2 ? REG_AW'(rt) : '0;

  logic [1:0][REG_AW-1:0] raddr;
  logic [1:0][DATA_W-1:0] rdata;
  logic [1:0][DATA_W-1:0] opv;
  logic [1:0]             ophz;
  logic                   hit;
  assign raddr = {rf_raddr2, rf_raddr1};
  assign rdata = {rf_rdata2, rf_rdata1};

  // Per-operand forwarding: lowest-index matching source wins; $0 is never forwarded
  always_comb begin
    opv  = '0;
    ophz = '0;
    hit  = 1'b0;
    for (int j = 0; j < 2; j++) begin
      opv[j] = rdata[j];
      hit    = 1'b0;
      for (int k = 0; k < FWD_N; k++) begin
        if (!hit && fwd_wreg[k] && fwd_wd[k*REG_AW +: REG_AW] == raddr[j]) begin
          hit     = 1'b1;
          ophz[j] = fwd_pend[k];
          opv[j]  = fwd_wdata[k*DATA_W +: DATA_W];
        end
      end
      if (raddr[j] == '0) begin
        opv[j]  = '0;
        ophz[j] = 1'b0;
      end
    end
  end

  logic [DATA_W-1:0] reg1_d, reg2_d;
  logic              adv, hazard;
  assign reg1_d   = sa_sel ? DATA_W'(sa) : opv[0];
  assign reg2_d   = imm_sel ? dec_imm : opv[1];
  assign adv      = !out_valid || out_ready;
  assign hazard   = in_valid && (|ophz);
  assign in_ready = adv && !hazard && !flush;

  // ID/EX register: flush beats load, bubble on hazard/no input, hold on back-pressure
  always_ff @(posedge clk) begin
    if (resetn) begin
      out_valid <= 1'b0;
      aluop_o   <= OP_NOP;
      alusel_o  <= 3'd0;
      reg1_o    <= '0;
      reg2_o    <= '0;
      wd_o      <= '0;
      wreg_o    <= 1'b0;
      pc_o      <= '0;
      illegal_o <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (hazard && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush) begin
        out_valid <= 1'b0;
      end else if (adv) begin
        if (in_valid && !hazard) begin
          out_valid <= 1'b1;
          aluop_o   <= dec_aluop;
          alusel_o  <= dec_alusel;
          reg1_o    <= reg1_d;
          reg2_o    <= reg2_d;
          wd_o      <= dec_wd;
          wreg_o    <= dec_wreg;
          pc_o      <= pc_i;
          illegal_o <= dec_ill;
        end else begin
          out_valid <= 1'b0;
          wreg_o    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_id_decode_stage.sv
// Self-checking bench for id_decode_stage: decode vector table with a scoreboard,
// plus hand sequences for stalls, back-pressure, flush, reset and counter saturation.
module tb_id_decode_stage;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned FWD_N  = 2;
  localparam int unsigned CNT_W  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    resetn, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0]             pc_i, inst_i, pc_o;
  logic [REG_AW-1:0]       rf_raddr1, rf_raddr2, wd_o;
  logic [DATA_W-1:0]       rf_rdata1, rf_rdata2, reg1_o, reg2_o;
  logic [FWD_N-1:0]        fwd_wreg, fwd_pend;
  logic [FWD_N*REG_AW-1:0] fwd_wd;
  logic [FWD_N*DATA_W-1:0] fwd_wdata;
  logic [7:0]              aluop_o;
  logic [2:0]              alusel_o;
  logic                    wreg_o, illegal_o;
  logic [CNT_W-1:0]        stall_cnt;

  id_decode_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_N(FWD_N), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .pc_i(pc_i), .inst_i(inst_i), .flush(flush),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_wreg(fwd_wreg), .fwd_wd(fwd_wd), .fwd_wdata(fwd_wdata), .fwd_pend(fwd_pend),
    .out_valid(out_valid), .out_ready(out_ready),
    .aluop_o(aluop_o), .alusel_o(alusel_o), .reg1_o(reg1_o), .reg2_o(reg2_o),
    .wd_o(wd_o), .wreg_o(wreg_o), .pc_o(pc_o), .illegal_o(illegal_o), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [31:0] inst;
    logic [1:0]  fw;
    logic [9:0]  fwd;
    logic [63:0] fdata;
    logic [31:0] rd1, rd2;
    logic [4:0]  ra1, ra2;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] r1, r2;
    logic [4:0]  wd;
    logic        wreg, ill;
  } vec_t;

  typedef struct {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] r1, r2, pc;
    logic [4:0]  wd;
    logic        wreg, ill;
  } exp_t;

  localparam int NV = 13;
  vec_t v[NV];
  exp_t sb[$];
  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(1));
    if (sb.size() == 0) begin
      total++;
      $display("FAIL %s.scoreboard: output present, got empty queue expected an entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".aluop"},   64'(aluop_o),   64'(e.aluop));
      chk({tag, ".alusel"},  64'(alusel_o),  64'(e.alusel));
      chk({tag, ".reg1"},    64'(reg1_o),    64'(e.r1));
      chk({tag, ".reg2"},    64'(reg2_o),    64'(e.r2));
      chk({tag, ".wd"},      64'(wd_o),      64'(e.wd));
      chk({tag, ".wreg"},    64'(wreg_o),    64'(e.wreg));
      chk({tag, ".illegal"}, 64'(illegal_o), 64'(e.ill));
      chk({tag, ".pc"},      64'(pc_o),      64'(e.pc));
    end
  endtask

  initial begin
    // inst, fw, fwd{src1,src0}, fdata{src1,src0}, rd1, rd2, ra1, ra2, aluop, alusel, r1, r2, wd, wreg, ill
    v[0]  = '{32'h34011100, 2'b00, 10'h000, 64'h0, 32'h0, 32'h0, 5'd0, 5'd0,
              8'h25, 3'd1, 32'h0, 32'h00001100, 5'd1, 1'b1, 1'b0};
    v[1]  = '{32'h00221825, 2'b11, 10'h021, 64'h00005555_0000AAAA, 32'h12345678, 32'h0F, 5'd1, 5'd2,
              8'h25, 3'd1, 32'h0000AAAA, 32'h0000000F, 5'd3, 1'b1, 1'b0};
    v[2]  = '{32'h00052024, 2'b01, 10'h000, 64'h00000000_FFFFFFFF, 32'hDEAD, 32'h77, 5'd0, 5'd5,
              8'h24, 3'd1, 32'h0, 32'h77, 5'd4, 1'b1, 1'b0};
    v[3]  = '{32'h00083900, 2'b00, 10'h000, 64'h0, 32'hBAD, 32'h11, 5'd0, 5'd8,
              8'h7C, 3'd2, 32'h4, 32'h11, 5'd7, 1'b1, 1'b0};
    v[4]  = '{32'h016A4807, 2'b10, 10'h160, 64'h0000001F_00000000, 32'h99, 32'h80000000, 5'd11, 5'd10,
              8'h03, 3'd2, 32'h1F, 32'h80000000, 5'd9, 1'b1, 1'b0};
    v[5]  = '{32'h3C0CABCD, 2'b00, 10'h000, 64'h0, 32'h5, 32'h6, 5'd0, 5'd0,
              8'h25, 3'd1, 32'h0, 32'hABCD0000, 5'd12, 1'b1, 1'b0};
    v[6]  = '{32'hFC000000, 2'b00, 10'h000, 64'h0, 32'h1, 32'h2, 5'd0, 5'd0,
              8'h00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1};
    v[7]  = '{32'h0000000F, 2'b00, 10'h000, 64'h0, 32'h1, 32'h2, 5'd0, 5'd0,
              8'h00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0};
    v[8]  = '{32'h01CF6827, 2'b01, 10'h00F, 64'h00000000_0000003C, 32'h1234, 32'hFFFF, 5'd14, 5'd15,
              8'h27, 3'd1, 32'h1234, 32'h3C, 5'd13, 1'b1, 1'b0};
    v[9]  = '{32'h3A308001, 2'b00, 10'h000, 64'h0, 32'hF0F0F0F0, 32'h0, 5'd17, 5'd0,
              8'h26, 3'd1, 32'hF0F0F0F0, 32'h8001, 5'd16, 1'b1, 1'b0};
    v[10] = '{32'h00000000, 2'b00, 10'h000, 64'h0, 32'h3, 32'h4, 5'd0, 5'd0,
              8'h7C, 3'd2, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0};
    v[11] = '{32'hCC000000, 2'b00, 10'h000, 64'h0, 32'h3, 32'h4, 5'd0, 5'd0,
              8'h00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0};
    v[12] = '{32'h00430865, 2'b00, 10'h000, 64'h0, 32'h3, 32'h4, 5'd0, 5'd0,
              8'h00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1};

    resetn = 1'b1; in_valid = 1'b0; pc_i = '0; inst_i = '0; flush = 1'b0;
    rf_rdata1 = '0; rf_rdata2 = '0; fwd_wreg = '0; fwd_wd = '0; fwd_wdata = '0;
    fwd_pend = '0; out_ready = 1'b1;
    tick();
    tick();
    resetn = 1'b0;
    chk("rst.out_valid", 64'(out_valid), 64'(0));
    chk("rst.aluop",     64'(aluop_o),   64'(0));
    chk("rst.alusel",    64'(alusel_o),  64'(0));
    chk("rst.reg1",      64'(reg1_o),    64'(0));
    chk("rst.reg2",      64'(reg2_o),    64'(0));
    chk("rst.wd",        64'(wd_o),      64'(0));
    chk("rst.wreg",      64'(wreg_o),    64'(0));
    chk("rst.pc",        64'(pc_o),      64'(0));
    chk("rst.illegal",   64'(illegal_o), 64'(0));
    chk("rst.stall_cnt", 64'(stall_cnt), 64'(0));

    // Back-to-back decode vectors, one per cycle
    for (int i = 0; i < NV; i++) begin
      inst_i = v[i].inst; pc_i = 32'h1000 + 32'(i * 4);
      fwd_wreg = v[i].fw; fwd_wd = v[i].fwd; fwd_wdata = v[i].fdata; fwd_pend = '0;
      rf_rdata1 = v[i].rd1; rf_rdata2 = v[i].rd2; in_valid = 1'b1;
      #1;
      chk($sformatf("v%0d.raddr1", i), 64'(rf_raddr1), 64'(v[i].ra1));
      chk($sformatf("v%0d.raddr2", i), 64'(rf_raddr2), 64'(v[i].ra2));
      chk($sformatf("v%0d.in_ready", i), 64'(in_ready), 64'(1));
      if (in_ready) sb.push_back('{v[i].aluop, v[i].alusel, v[i].r1, v[i].r2, pc_i, v[i].wd, v[i].wreg, v[i].ill});
      tick();
      check_out($sformatf("v%0d", i));
    end

    // Load-use stall: xor $6,$2,$2 with source 0 pending on $2
    inst_i = 32'h00423026; pc_i = 32'h2000; rf_rdata1 = 32'h9; rf_rdata2 = 32'h9;
    fwd_wreg = 2'b01; fwd_wd = 10'h002; fwd_wdata = '0; fwd_pend = 2'b01;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d.in_ready", c), 64'(in_ready), 64'(0));
      tick();
      chk($sformatf("stall%0d.out_valid", c), 64'(out_valid), 64'(0));
      chk($sformatf("stall%0d.wreg", c), 64'(wreg_o), 64'(0));
    end
    chk("stall.cnt3", 64'(stall_cnt), 64'(3));
    fwd_pend = 2'b00; fwd_wdata = 64'h00000000_00001357;
    #1;
    chk("stall_release.in_ready", 64'(in_ready), 64'(1));
    if (in_ready) sb.push_back('{8'h26, 3'd1, 32'h1357, 32'h1357, pc_i, 5'd6, 1'b1, 1'b0});
    tick();
    check_out("stall_release");
    chk("stall_release.cnt", 64'(stall_cnt), 64'(3));

    // Back-pressure holds the register, then flush drops it
    out_ready = 1'b0; fwd_wreg = '0; inst_i = 32'h34011100; pc_i = 32'h3000;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("bp%0d.in_ready", c), 64'(in_ready), 64'(0));
      tick();
      chk($sformatf("bp%0d.out_valid", c), 64'(out_valid), 64'(1));
      chk($sformatf("bp%0d.aluop", c), 64'(aluop_o), 64'(8'h26));
      chk($sformatf("bp%0d.reg1", c), 64'(reg1_o), 64'(32'h1357));
      chk($sformatf("bp%0d.pc", c), 64'(pc_o), 64'(32'h2000));
    end
    flush = 1'b1;
    #1;
    chk("flush.in_ready", 64'(in_ready), 64'(0));
    tick();
    chk("flush.out_valid", 64'(out_valid), 64'(0));
    flush = 1'b0; out_ready = 1'b1; inst_i = 32'h00083900; pc_i = 32'h3004; rf_rdata2 = 32'h11;
    #1;
    chk("post_flush.in_ready", 64'(in_ready), 64'(1));
    if (in_ready) sb.push_back('{8'h7C, 3'd2, 32'h4, 32'h11, pc_i, 5'd7, 1'b1, 1'b0});
    tick();
    check_out("post_flush");
    chk("post_flush.cnt", 64'(stall_cnt), 64'(3));

    // Reset in the middle of a stall, then saturation of the 4-bit counter
    inst_i = 32'h00423026; pc_i = 32'h4000; fwd_wreg = 2'b01; fwd_wd = 10'h002; fwd_pend = 2'b01;
    tick();
    tick();
    chk("mid.cnt5", 64'(stall_cnt), 64'(5));
    chk("mid.out_valid", 64'(out_valid), 64'(0));
    resetn = 1'b1;
    tick();
    resetn = 1'b0;
    chk("mid_rst.cnt", 64'(stall_cnt), 64'(0));
    chk("mid_rst.out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst.aluop", 64'(aluop_o), 64'(0));
    tick();
    chk("after_rst.cnt", 64'(stall_cnt), 64'(1));
    for (int c = 0; c < 20; c++) tick();
    chk("sat.cnt", 64'(stall_cnt), 64'(4'hF));
    in_valid = 1'b0; fwd_pend = '0;
    tick();
    chk("idle.out_valid", 64'(out_valid), 64'(0));
    chk("idle.cnt", 64'(stall_cnt), 64'(4'hF));
    chk("idle.scoreboard_empty", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/id_decode_stage.md
Name: id_decode_stage

Overview:
- Registered, parametrised instruction-decode stage for the multi-cycle/pipelined MIPS core.
- Sits between the fetch (IF/ID) and execute stages:
  - decodes the logic and shift instruction subset;
  - reads the register file, selecting among N forwarding sources;
  - detects load-use (pending-result) hazards and stalls;
  - drives a valid/ready-handshaked ID/EX pipeline register.
- Adds flush, $0 protection, illegal-instruction flagging and a saturating stall counter.

Parameters:
- DATA_W, 32: datapath width, must be ≥32. Immediates are zero-extended to DATA_W.
- REG_AW, 5: register address width.
- FWD_N, 2: number of forwarding sources. Index 0 has the highest priority (youngest, e.g. EX), then 1 (MEM), and so on.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  reset; one clock; reset is synchronous and active-high
- in_valid  in  1  pc_i/inst_i valid
- in_ready  out  1  stage accepts the instruction this cycle
- pc_i  in  32  instruction PC
- inst_i  in  32  instruction word
- flush  in  1  kill the in-flight and the incoming instruction
- rf_raddr1  out  REG_AW  register-file read address, port 1 (rs), combinational
- rf_raddr2  out  REG_AW  register-file read address, port 2 (rt), combinational
- rf_rdata1  in  DATA_W  register-file read data, port 1
- rf_rdata2  in  DATA_W  register-file read data, port 2
- fwd_wreg  in  FWD_N  per-source write enable
- fwd_wd  in  FWD_N*REG_AW  per-source destination register
- fwd_wdata  in  FWD_N*DATA_W  per-source result
- fwd_pend  in  FWD_N  per-source result not yet available (load in flight)
- out_valid  out  1  ID/EX register holds a valid instruction
- out_ready  in  1  execute stage consumes the instruction
- aluop_o  out  8  ALU operation
- alusel_o  out  3  result class
- reg1_o  out  DATA_W  operand 1
- reg2_o  out  DATA_W  operand 2
- wd_o  out  REG_AW  destination register
- wreg_o  out  1  destination write enable
- pc_o  out  32  PC of the registered instruction
- illegal_o  out  1  unsupported opcode (registered alongside the outputs)
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset (resetn=1 at a clock edge): every registered output goes to 0, including out_valid, aluop_o (NOP 8'h00), alusel_o, operands, wd_o, wreg_o, pc_o, illegal_o and stall_cnt.
- Decode is combinational from inst_i, with op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], sa=[10:6], funct=[5:0].
- SPECIAL (op=0) with sa=0:
  - funct AND/OR/XOR/NOR (24/25/26/27 hex): aluop 24/25/26/27, alusel LOGIC=1.
  - SLLV/SRLV/SRAV (04/06/07): aluop 7C/02/03, alusel SHIFT=2.
  - For all of these: reg1=rs, reg2=rt, wd=rd, wreg=1.
- SLL/SRL/SRA (funct 00/02/03) with inst[31:21]=0:
  - alusel SHIFT, aluop 7C/02/03.
  - reg1=zero-extended sa (no rs read), reg2=rt, wd=rd, wreg=1.
  - inst_i=0 is SLL $0 and is therefore a NOP.
- ANDI/ORI/XORI (0C/0D/0E): reg1=rs, reg2=zero-extended imm16, wd=rt, wreg=1.
- LUI (0F): aluop OR, reg1=rs, reg2=imm16<<16 (zero-extended), wd=rt.
- SYNC (SPECIAL funct 0F) and PREF (op 33): aluop NOP, alusel 0, wreg=0, no register reads.
- Anything else: NOP decode with illegal=1.
- rf_raddr1/rf_raddr2 output rs/rt combinationally, and are 0 when the operand is unused.
- Operand resolution, per enabled register operand with read address a:
  - a=0: the operand is 0; never forwarded and never a hazard.
  - Otherwise, use the lowest-index source k with fwd_wreg[k]=1 and fwd_wd[k]=a.
    - If fwd_pend[k]=1, a hazard is flagged.
    - Otherwise the operand is fwd_wdata[k].
  - If no source matches, the operand is rf_rdata.
- Handshake:
  - adv = !out_valid | out_ready
  - hazard = in_valid & (any operand hazard)
  - in_ready = adv & !hazard & !flush
- Clocked update, in priority order:
  1. reset
  2. flush: out_valid←0. The incoming instruction is dropped; in_ready=0 that cycle, so fetch must hold or refetch it.
  3. adv & in_valid & !hazard: load all decoded outputs, out_valid←1.
  4. adv & (hazard | !in_valid): out_valid←0 (bubble). Other outputs may hold stale values, but wreg_o←0.
  5. !adv: hold every output unchanged (back-pressure). The hazard is re-evaluated every cycle.
- stall_cnt increments by 1 on each cycle with hazard=1 and no reset; it saturates at all-ones.
- Latency: one cycle from acceptance to out_valid.
- Throughput: one instruction per cycle when there is no hazard or back-pressure.

Test Plan:
- Reset, then `ori $1,$0,0x1100` with rf idle → next cycle out_valid=1, aluop_o=25, alusel_o=1, reg1_o=0, reg2_o=0x00001100, wd_o=1, wreg_o=1, illegal_o=0.
- `or $3,$1,$2` with fwd0={wreg=1,wd=1,data=0xAAAA}, fwd1={wreg=1,wd=1,data=0x5555}, rf_rdata2=0x0F → reg1_o=0xAAAA (priority to source 0), reg2_o=0x0F.
- `and $4,$0,$5` with fwd0={wreg=1,wd=0,data=0xFFFF_FFFF} → reg1_o=0; no forwarding into $0.
- fwd0={wreg=1,wd=2,pend=1} for 3 cycles while `xor $6,$2,$2` is presented → in_ready=0 and out_valid=0 for 3 cycles, stall_cnt=3; when pend drops, the instruction is issued with the forwarded data.
- out_ready=0 for 2 cycles while out_valid=1 → outputs stable and in_ready=0; then flush=1 → out_valid=0 next cycle; the following SLL with sa=4 gives reg1_o=4, aluop_o=7C.
- inst_i=0xFC000000 → illegal_o=1, wreg_o=0, aluop_o=0. Asserting resetn mid-stall clears stall_cnt and out_valid on the next edge.
